// File: rtl/rotate_fb_ctrl_if.sv
// rotate_fb_ctrl_if: write-side bus from the rotation controller to the
// dual-port rotation RAM.
//   wr_en    : one-cycle write strobe. There is no ready/backpressure: the
//              RAM accepts a write on every cycle where wr_en is high, and
//              wr_addr/wr_data are only meaningful in that cycle.
//   wr_addr  : RAM write address (AW bits)
//   wr_data  : RAM write data (DEPTH bits)
// master = controller (drives), slave = RAM side / observer.
interface rotate_fb_ctrl_if #(
  parameter int AW    = 18,
  parameter int DEPTH = 8
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DEPTH-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/rotate_fb_ctrl.sv
// rotate_fb_ctrl: triple-buffer controller and rotated write-address
// sequencer for the rotation frame store.
//
// Incoming raster pixels are written column-wise so that the stored frame is
// rotated by 90 degrees (CCW=0: clockwise, CCW=1: counter-clockwise). Three
// banks of WIDTH*HEIGHT pixels are rotated between writer, reader and
// "pending" (newest complete frame) roles.
//
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   ce_pix          : source pixel clock enable
//   video_in        : source pixel
//   hblank, vblank  : source blanking
//   rd_frame_start  : one-cycle pulse, reader starts a frame
//   wr              : RAM write bus (wr_en/wr_addr/wr_data, registered)
//   wr_bank         : bank being written
//   rd_bank/rd_base : bank granted to the reader and its base address
//   drop_cnt        : saturating count of complete frames overwritten unread
//   repeat_cnt      : saturating count of reader frames with no new frame
//   dbg_p_bank      : pending bank index
//   dbg_p_valid     : pending bank holds an unread complete frame
//   dbg_armed       : writer has seen a vblank edge since reset
module rotate_fb_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int AW     = 18,
  parameter int DEPTH  = 8,
  parameter int CCW    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             rd_frame_start,
  rotate_fb_ctrl_if.master wr,
  output logic [1:0]       wr_bank,
  output logic [1:0]       rd_bank,
  output logic [AW-1:0]    rd_base,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       repeat_cnt,
  output logic [1:0]       dbg_p_bank,
  output logic             dbg_p_valid,
  output logic             dbg_armed
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] X_LIM = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(HEIGHT);
  localparam logic [AW-1:0] BS    = AW'(WIDTH * HEIGHT);
  localparam logic [AW-1:0] HT    = AW'(HEIGHT);
  localparam logic [AW-1:0] ONE   = AW'(1);

  function automatic logic [AW-1:0] bank_base(input logic [1:0] k);
    case (k)
      2'd1:    bank_base = BS;
      2'd2:    bank_base = BS + BS;
      default: bank_base = '0;
    endcase
  endfunction

  // First pixel of a frame: top-right corner of the rotated image for CW
  // (column HEIGHT-1 of row 0), bottom-left for CCW (row WIDTH-1, column 0).
  function automatic logic [AW-1:0] row_start(input logic [1:0] k);
    if (CCW != 0) row_start = bank_base(k) + BS - HT;
    else          row_start = bank_base(k) + HT - ONE;
  endfunction

  logic [1:0]       r_w, r_r, r_p;
  logic             r_pv, r_armed, r_wr_any;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [AW-1:0]    r_row, r_addr, r_rd_base;
  logic             r_old_blank, r_old_vblank;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [DEPTH-1:0] r_wr_data;
  logic [7:0]       r_drop, r_repeat;

  logic          w_blank, w_line_end, w_frame_end, w_pix;
  logic [AW-1:0] w_row_next, w_addr_next;
  logic [1:0]    w_nw, w_nr, w_np;
  logic          w_npv, w_drop_inc, w_rep_inc;

  assign w_blank     = hblank | vblank;
  assign w_line_end  = w_blank & ~r_old_blank;
  assign w_frame_end = vblank & ~r_old_vblank;
  assign w_pix       = ce_pix & ~w_blank & r_armed & (r_x < X_LIM) & (r_y < Y_LIM);
  assign w_row_next  = (CCW != 0) ? r_row + ONE : r_row - ONE;
  assign w_addr_next = (CCW != 0) ? r_addr - HT : r_addr + HT;

  // Bank rotation: publish (frame end) is resolved first, then the reader
  // grant sees the post-publish pending state, so a simultaneous frame end
  // and reader request hands the just-finished frame straight to the reader.
  always_comb begin
    w_nw       = r_w;
    w_nr       = r_r;
    w_np       = r_p;
    w_npv      = r_pv;
    w_drop_inc = 1'b0;
    w_rep_inc  = 1'b0;
    if (w_frame_end && r_wr_any) begin
      w_nw       = r_p;
      w_np       = r_w;
      w_npv      = 1'b1;
      w_drop_inc = r_pv;
    end
    if (rd_frame_start) begin
      if (w_npv) begin
        w_nr  = w_np;
        w_np  = r_r;
        w_npv = 1'b0;
      end else begin
        w_rep_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w          <= 2'd0;
      r_r          <= 2'd1;
      r_p          <= 2'd2;
      r_pv         <= 1'b0;
      r_armed      <= 1'b0;
      r_wr_any     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      r_rd_base    <= BS;
      r_old_blank  <= 1'b0;
      r_old_vblank <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_drop       <= '0;
      r_repeat     <= '0;
    end else begin
      r_old_blank  <= w_blank;
      r_old_vblank <= vblank;
      r_w          <= w_nw;
      r_r          <= w_nr;
      r_p          <= w_np;
      r_pv         <= w_npv;
      r_rd_base    <= bank_base(w_nr);
      if (w_drop_inc && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_rep_inc && r_repeat != 8'hFF) r_repeat <= r_repeat + 8'd1;

      r_wr_en <= w_pix;
      if (w_pix) begin
        r_wr_addr <= r_addr;
        r_wr_data <= video_in;
        r_addr    <= w_addr_next;
        r_x       <= r_x + XW'(1);
        r_wr_any  <= 1'b1;
      end

      // w_pix requires ~blank, so these never collide with a pixel write.
      if (w_frame_end) begin
        r_row    <= row_start(w_nw);
        r_addr   <= row_start(w_nw);
        r_x      <= '0;
        r_y      <= '0;
        r_wr_any <= 1'b0;
        r_armed  <= 1'b1;
      end else if (w_line_end) begin
        r_x <= '0;
        // Lines past HEIGHT are dropped without moving the row pointer.
        if (r_y < Y_LIM) begin
          r_y    <= r_y + YW'(1);
          r_row  <= w_row_next;
          r_addr <= w_row_next;
        end
      end
    end
  end

  assign wr.wr_en    = r_wr_en;
  assign wr.wr_addr  = r_wr_addr;
  assign wr.wr_data  = r_wr_data;
  assign wr_bank     = r_w;
  assign rd_bank     = r_r;
  assign rd_base     = r_rd_base;
  assign drop_cnt    = r_drop;
  assign repeat_cnt  = r_repeat;
  assign dbg_p_bank  = r_p;
  assign dbg_p_valid = r_pv;
  assign dbg_armed   = r_armed;

endmodule

// File: tb/tb_rotate_fb_ctrl.sv
// tb_rotate_fb_ctrl: directed bench for rotate_fb_ctrl with WIDTH=4,
// HEIGHT=3. A clockwise and a counter-clockwise instance share stimulus; each
// has its own expected-write queue drained by a negedge monitor.
module tb_rotate_fb_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 18;
  localparam int D  = 8;
  localparam int BS = W * H;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ce_pix = 1'b0;
  logic [D-1:0] video_in = '0;
  logic         hblank = 1'b0;
  logic         vblank = 1'b0;
  logic         rd_frame_start = 1'b0;

  logic [1:0]    cw_wr_bank, cw_rd_bank, cw_p_bank, ccw_wr_bank, ccw_rd_bank, ccw_p_bank;
  logic [AW-1:0] cw_rd_base, ccw_rd_base;
  logic [7:0]    cw_drop, cw_repeat, ccw_drop, ccw_repeat;
  logic          cw_pv, cw_armed, ccw_pv, ccw_armed;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rotate_fb_ctrl_if #(.AW(AW), .DEPTH(D)) bus_cw ();
  rotate_fb_ctrl_if #(.AW(AW), .DEPTH(D)) bus_ccw ();

  rotate_fb_ctrl #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DEPTH(D), .CCW(0)) u_cw (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .video_in(video_in),
    .hblank(hblank), .vblank(vblank), .rd_frame_start(rd_frame_start),
    .wr(bus_cw), .wr_bank(cw_wr_bank), .rd_bank(cw_rd_bank), .rd_base(cw_rd_base),
    .drop_cnt(cw_drop), .repeat_cnt(cw_repeat),
    .dbg_p_bank(cw_p_bank), .dbg_p_valid(cw_pv), .dbg_armed(cw_armed)
  );

  rotate_fb_ctrl #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DEPTH(D), .CCW(1)) u_ccw (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .video_in(video_in),
    .hblank(hblank), .vblank(vblank), .rd_frame_start(rd_frame_start),
    .wr(bus_ccw), .wr_bank(ccw_wr_bank), .rd_bank(ccw_rd_bank), .rd_base(ccw_rd_base),
    .drop_cnt(ccw_drop), .repeat_cnt(ccw_repeat),
    .dbg_p_bank(ccw_p_bank), .dbg_p_valid(ccw_pv), .dbg_armed(ccw_armed)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 1'b0;
  bit rand_mode = 1'b0;
  logic [AW+D-1:0] exp_cw_q[$];
  logic [AW+D-1:0] exp_ccw_q[$];
  logic [AW+D-1:0] e_cw, e_ccw;

  // Hand-computed bank-0 write order for 4x3, line by line.
  int cw_tab[12]  = '{2, 5, 8, 11, 1, 4, 7, 10, 0, 3, 6, 9};
  int ccw_tab[12] = '{9, 6, 3, 0, 10, 7, 4, 1, 11, 8, 5, 2};

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vblank_pulse();
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    tick();
  endtask

  task automatic rd_pulse();
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
    tick();
  endtask

  task automatic push_pix(input int bank, input int idx, input logic [D-1:0] data);
    exp_cw_q.push_back({AW'(cw_tab[idx] + bank * BS), data});
    exp_ccw_q.push_back({AW'(ccw_tab[idx] + bank * BS), data});
  endtask

  // One source frame of H lines x W pixels, each line followed by hblank.
  task automatic frame(input int bank, input int seed, input bit expect_wr);
    for (int l = 0; l < H; l++) begin
      for (int p = 0; p < W; p++) begin
        ce_pix   = 1'b1;
        video_in = D'(seed + l * W + p);
        if (expect_wr) push_pix(bank, l * W + p, video_in);
        tick();
      end
      ce_pix = 1'b0;
      hblank = 1'b1;
      tick();
      hblank = 1'b0;
      tick();
    end
  endtask

  task automatic chk_banks(input string tag, input int w, input int r, input int p, input int pv);
    chk({tag, "_wr_bank"}, cw_wr_bank, w);
    chk({tag, "_rd_bank"}, cw_rd_bank, r);
    chk({tag, "_p_bank"}, cw_p_bank, p);
    chk({tag, "_p_valid"}, cw_pv, pv);
    chk({tag, "_rd_base"}, cw_rd_base, r * BS);
    chk({tag, "_ccw_wr_bank"}, ccw_wr_bank, w);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      n_checks++;
      if (cw_rd_bank == cw_wr_bank || cw_rd_bank == cw_p_bank || cw_wr_bank == cw_p_bank ||
          cw_wr_bank > 2'd2 || cw_rd_bank > 2'd2 || cw_p_bank > 2'd2) begin
        n_errors++;
        $display("FAIL bank_perm: w=%0d r=%0d p=%0d", cw_wr_bank, cw_rd_bank, cw_p_bank);
      end
      if (rand_mode) begin
        if (bus_cw.wr_en)
          chk("rand_cw_in_bank", (int'(bus_cw.wr_addr) / BS), int'(cw_wr_bank));
        if (bus_ccw.wr_en)
          chk("rand_ccw_in_bank", (int'(bus_ccw.wr_addr) / BS), int'(ccw_wr_bank));
      end else begin
        if (bus_cw.wr_en) begin
          if (exp_cw_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL cw_unexpected_write: got addr %0d expected no write", bus_cw.wr_addr);
          end else begin
            e_cw = exp_cw_q.pop_front();
            chk("cw_wr_addr", bus_cw.wr_addr, e_cw[AW+D-1:D]);
            chk("cw_wr_data", bus_cw.wr_data, e_cw[D-1:0]);
          end
        end
        if (bus_ccw.wr_en) begin
          if (exp_ccw_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ccw_unexpected_write: got addr %0d expected no write", bus_ccw.wr_addr);
          end else begin
            e_ccw = exp_ccw_q.pop_front();
            chk("ccw_wr_addr", bus_ccw.wr_addr, e_ccw[AW+D-1:D]);
            chk("ccw_wr_data", bus_ccw.wr_data, e_ccw[D-1:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    tick();
    tick();
    tick();
    mon_on = 1'b1;
    chk("rst_wr_en", bus_cw.wr_en, 0);
    chk("rst_wr_addr", bus_cw.wr_addr, 0);
    chk("rst_drop", cw_drop, 0);
    chk("rst_repeat", cw_repeat, 0);
    chk("rst_ccw_rd_base", ccw_rd_base, BS);
    chk_banks("rst", 0, 1, 2, 0);
    reset = 1'b0;
    tick();

    // Unarmed writer: a whole frame of pixels produces no writes.
    frame(0, 8'h80, 1'b0);
    chk("unarmed", cw_armed, 0);
    vblank_pulse();
    chk("armed", cw_armed, 1);
    chk_banks("arm", 0, 1, 2, 0);

    frame(0, 8'h10, 1'b1);
    chk_banks("f0", 0, 1, 2, 0);
    vblank_pulse();
    chk_banks("pub0", 2, 1, 0, 1);
    chk("pub0_drop", cw_drop, 0);

    rd_pulse();
    chk_banks("grant0", 2, 0, 1, 0);

    frame(2, 8'h20, 1'b1);
    vblank_pulse();
    chk_banks("pub2", 1, 0, 2, 1);
    frame(1, 8'h30, 1'b1);
    vblank_pulse();
    chk_banks("pub1", 2, 0, 1, 1);
    chk("drop_one", cw_drop, 1);
    chk("ccw_drop_one", ccw_drop, 1);

    rd_pulse();
    chk_banks("grant1", 2, 1, 0, 0);
    chk("no_repeat", cw_repeat, 0);
    rd_pulse();
    chk_banks("repeat", 2, 1, 0, 0);
    chk("repeat_one", cw_repeat, 1);

    // Build w=0, r=1, p=2, p_valid=1, then frame end + reader request together.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    vblank_pulse();
    frame(0, 8'h40, 1'b1);
    vblank_pulse();
    frame(2, 8'h50, 1'b1);
    vblank_pulse();
    chk_banks("pre_sim", 0, 1, 2, 1);
    chk("pre_sim_drop", cw_drop, 1);
    frame(0, 8'h60, 1'b1);
    vblank = 1'b1;
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
    tick();
    vblank = 1'b0;
    tick();
    chk_banks("sim", 2, 0, 1, 0);
    chk("sim_drop", cw_drop, 2);
    chk("sim_repeat", cw_repeat, 0);

    for (int i = 0; i < 300; i++) rd_pulse();
    chk("repeat_sat", cw_repeat, 255);
    chk("ccw_repeat_sat", ccw_repeat, 255);
    chk_banks("sat", 2, 0, 1, 0);

    // Reset in the middle of a line while a write is on the bus.
    ce_pix = 1'b1;
    video_in = 8'hA0;
    push_pix(2, 0, video_in);
    tick();
    video_in = 8'hA1;
    push_pix(2, 1, video_in);
    tick();
    chk("pre_rst_wr_en", bus_cw.wr_en, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_wr_en", bus_cw.wr_en, 0);
    chk("mid_rst_ccw_wr_en", bus_ccw.wr_en, 0);
    reset = 1'b0;
    tick();
    chk_banks("mid_rst", 0, 1, 2, 0);
    chk("mid_rst_repeat", cw_repeat, 0);
    ce_pix = 1'b0;
    tick();
    frame(0, 8'hB0, 1'b0);
    vblank_pulse();
    frame(0, 8'hC0, 1'b1);
    chk("q_cw_drained", exp_cw_q.size(), 0);
    chk("q_ccw_drained", exp_ccw_q.size(), 0);

    // Random raster/reader activity: bank permutation and write containment.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ce_pix         = 1'($urandom_range(0, 1));
      hblank         = ($urandom_range(0, 7) == 0);
      vblank         = ($urandom_range(0, 40) == 0);
      rd_frame_start = ($urandom_range(0, 20) == 0);
      video_in       = D'($urandom_range(0, 255));
      tick();
    end
    ce_pix = 1'b0;
    hblank = 1'b0;
    vblank = 1'b0;
    rd_frame_start = 1'b0;
    tick();
    tick();
    rand_mode = 1'b0;
    mon_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
